// File: rtl/reg_alu_sequencer_pkg.sv
// Shared definitions for the register-bank/ALU command sequencer:
// ALU opcodes, FSM state encodings and command field widths.
package reg_alu_sequencer_pkg;

  localparam int OP_WIDTH  = 3;
  localparam int REG_WIDTH = 4;
  localparam int CMD_WIDTH = OP_WIDTH + 3 * REG_WIDTH;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_RETIRE = 2'd3;

endpackage

// File: rtl/reg_alu_sequencer_if.sv
// Command channel into the sequencer: valid/ready handshake
// carrying one {op, rd, rs, rt} ALU command per transfer.
interface reg_alu_sequencer_if #(
  parameter int OP_W       = 3,
  parameter int REG_ADDR_W = 4
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [OP_W-1:0]       cmd_op;
  logic [REG_ADDR_W-1:0] cmd_rd;
  logic [REG_ADDR_W-1:0] cmd_rs;
  logic [REG_ADDR_W-1:0] cmd_rt;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt,
    output cmd_ready
  );
endinterface

// File: rtl/reg_alu_sequencer_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; push is
// ignored when full, pop is ignored when empty.
module reg_alu_sequencer_cmd_fifo #(
  parameter int W     = 15,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/reg_alu_sequencer.sv
// Sequences queued ALU commands onto the register-bank datapath:
// pop, settle addresses, pulse execute, then report retirement.
module reg_alu_sequencer
  import reg_alu_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int REG_ADDR_W    = 4,
  parameter int OP_W          = 3,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  reg_alu_sequencer_if.slave          cmd,
  input  logic                        halt,
  output logic [OP_W-1:0]             alu_op,
  output logic [REG_ADDR_W-1:0]       rs_addr,
  output logic [REG_ADDR_W-1:0]       rt_addr,
  output logic [REG_ADDR_W-1:0]       rd_addr,
  output logic                        execute,
  output logic                        done,
  output logic [REG_ADDR_W-1:0]       done_rd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]            ops_count
);
  localparam int CW = OP_W + 3 * REG_ADDR_W;
  localparam int SW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_INIT =
    SW'(SETTLE_CYCLES - 1);

  logic [1:0]    state;
  logic [SW-1:0] settle;
  logic [CW-1:0] head;
  logic          full;
  logic          empty;
  logic          pop;

  assign cmd.cmd_ready = ~full;
  assign busy = (state != S_IDLE);

  // Pops happen only from IDLE or RETIRE, never while halted.
  assign pop = ((state == S_IDLE) || (state == S_RETIRE))
             & ~empty & ~halt;

  reg_alu_sequencer_cmd_fifo #(
    .W     (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd.cmd_valid),
    .wdata ({cmd.cmd_op, cmd.cmd_rd,
             cmd.cmd_rs, cmd.cmd_rt}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      settle    <= '0;
      alu_op    <= '0;
      rs_addr   <= '0;
      rt_addr   <= '0;
      rd_addr   <= '0;
      execute   <= 1'b0;
      done      <= 1'b0;
      done_rd   <= '0;
      ops_count <= '0;
    end else begin
      execute <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_SETUP: begin
          if (settle == '0) begin
            state   <= S_EXEC;
            execute <= 1'b1;
          end else begin
            settle <= settle - SW'(1);
          end
        end
        S_EXEC: begin
          state     <= S_RETIRE;
          done      <= 1'b1;
          done_rd   <= rd_addr;
          ops_count <= ops_count + CNT_W'(1);
        end
        S_RETIRE: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
      // A pop overrides the IDLE/RETIRE next-state above.
      if (pop) begin
        {alu_op, rd_addr, rs_addr, rt_addr} <= head;
        settle <= SETTLE_INIT;
        state  <= S_SETUP;
      end
    end
  end

endmodule
